video_shifter: RTL and testbench

- Source-side 15 kHz video generator: produces the shifter video interface (hs, vs, 6-bit RGB) consumed by the line doubler.
- Generates H/V timing and fetches 4-bit palette indices from a framebuffer over a fixed-latency read port.
- Maps each index through a 16-entry 18-bit palette and drives border colour outside the active window.
- Runs on the 16 MHz clock. One pixel spans 2 clocks, giving 320x200 active pixels and a 1024-clock line.

---
 rtl/video_pkg.sv | 51 +++++
 rtl/video_palette.sv | 30 +++
 rtl/video_shifter.sv | 138 +++++++++++++
 tb/tb_video_shifter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - timing constants and colour layout shared by the video shifter
// Ports: none (package).
package video_pkg;

    // Raster geometry in 16 MHz clocks / lines.
    localparam int H_TOTAL  = 1024;
    localparam int H_ACTIVE = 640;
    localparam int HS_START = 800;
    localparam int HS_LEN   = 76;
    localparam int V_TOTAL  = 312;
    localparam int V_START  = 56;
    localparam int V_ACTIVE = 200;
    localparam int VS_START = 290;
    localparam int VS_LEN   = 3;

    // Border stops 16 clocks ahead of hsync and is suppressed 8 lines either side of vsync.
    localparam int BORDER_H_GUARD = 16;
    localparam int BORDER_V_GUARD = 8;

    localparam int HCNT_W = 10;
    localparam int VCNT_W = 9;

    // Counter-width copies so comparisons stay width-matched.
    localparam logic [HCNT_W-1:0] H_LAST_C     = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_ACT_END_C  = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] HS_START_C   = HCNT_W'(HS_START);
    localparam logic [HCNT_W-1:0] HS_END_C     = HCNT_W'(HS_START + HS_LEN);
    localparam logic [HCNT_W-1:0] BORDER_H_END = HCNT_W'(HS_START - BORDER_H_GUARD);
    localparam logic [VCNT_W-1:0] V_LAST_C     = VCNT_W'(V_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_START_C    = VCNT_W'(V_START);
    localparam logic [VCNT_W-1:0] V_END_C      = VCNT_W'(V_START + V_ACTIVE);
    localparam logic [VCNT_W-1:0] VS_START_C   = VCNT_W'(VS_START);
    localparam logic [VCNT_W-1:0] VS_END_C     = VCNT_W'(VS_START + VS_LEN);
    localparam logic [VCNT_W-1:0] VB_START_C   = VCNT_W'(VS_START - BORDER_V_GUARD);
    localparam logic [VCNT_W-1:0] VB_END_C     = VCNT_W'(VS_START + VS_LEN + BORDER_V_GUARD);

    // rgb18 layout: {r[5:0], g[5:0], b[5:0]}.
    localparam int COLOR_BITS = 6;
    localparam int RGB_BITS   = 3 * COLOR_BITS;
    localparam int R_HI = 17;
    localparam int R_LO = 12;
    localparam int G_HI = 11;
    localparam int G_LO = 6;
    localparam int B_HI = 5;
    localparam int B_LO = 0;

    localparam int PAL_IDX_W = 4;
    localparam int PAL_DEPTH = 16;
    localparam int ADDR_W    = 16;

endpackage

// File: rtl/video_palette.sv
// rtl/video_palette.sv - 16x18 palette register file, one write port, one async read port
// Ports: clk/reset (async high); we, waddr, wdata write port; raddr -> rdata combinational read.
// A write lands on the clock edge, so a read in the same cycle still returns the old entry.
module video_palette
    import video_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [PAL_IDX_W-1:0] waddr,
    input  logic [RGB_BITS-1:0]  wdata,
    input  logic [PAL_IDX_W-1:0] raddr,
    output logic [RGB_BITS-1:0]  rdata
);

    logic [RGB_BITS-1:0] mem [PAL_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PAL_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/video_shifter.sv
// rtl/video_shifter.sv - 15 kHz raster generator: timing, framebuffer fetch, palette lookup
// Ports: clk, reset (async high); fetch_addr out / fetch_data in (1-clock read latency);
//        border_idx; pal_we/pal_addr/pal_data palette writes;
//        hs_out, vs_out (active low), vblank, r_out/g_out/b_out (6-bit each).
// Pipeline: stage 0 counters + classification, stage 1 fetch data + palette read,
//           stage 2 output registers. Position-to-output latency is 2 clocks.
module video_shifter
    import video_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_W-1:0]     fetch_addr,
    input  logic [PAL_IDX_W-1:0]  fetch_data,
    input  logic [PAL_IDX_W-1:0]  border_idx,
    input  logic                  pal_we,
    input  logic [PAL_IDX_W-1:0]  pal_addr,
    input  logic [RGB_BITS-1:0]   pal_data,
    output logic                  hs_out,
    output logic                  vs_out,
    output logic                  vblank,
    output logic [COLOR_BITS-1:0] r_out,
    output logic [COLOR_BITS-1:0] g_out,
    output logic [COLOR_BITS-1:0] b_out
);

    logic [HCNT_W-1:0] hcnt;
    logic [VCNT_W-1:0] vcnt;
    logic [ADDR_W-1:0] addr_q;

    logic h_wrap;
    logic frame_wrap;
    logic v_act0;
    logic active0;
    logic hs_n0;
    logic vs_n0;
    logic border0;

    logic active1;
    logic border1;
    logic hs_n1;
    logic vs_n1;
    logic v_act1;

    logic [PAL_IDX_W-1:0] lookup_idx;
    logic [RGB_BITS-1:0]  pal_rgb;
    logic [RGB_BITS-1:0]  pix_rgb;

    // Stage 0: raster counters.
    assign h_wrap     = (hcnt == H_LAST_C);
    assign frame_wrap = h_wrap && (vcnt == V_LAST_C);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_wrap) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST_C) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // Stage 0: classify the current position.
    always_comb begin
        v_act0  = (vcnt >= V_START_C) && (vcnt < V_END_C);
        active0 = (hcnt < H_ACT_END_C) && v_act0;
        hs_n0   = !((hcnt >= HS_START_C) && (hcnt < HS_END_C));
        vs_n0   = !((vcnt >= VS_START_C) && (vcnt < VS_END_C));
        border0 = !active0 && (hcnt < BORDER_H_END)
                  && !((vcnt >= VB_START_C) && (vcnt < VB_END_C));
    end

    // Pixel address: advances after the second clock of each active pixel and is cleared
    // on the frame wrap so it already reads 0 while the counters sit at (0,0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
        end else if (frame_wrap) begin
            addr_q <= '0;
        end else if (active0 && hcnt[0]) begin
            addr_q <= addr_q + 1'b1;
        end
    end

    assign fetch_addr = addr_q;

    // Stage 1: the framebuffer returns fetch_data now; the position flags are delayed to match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active1 <= 1'b0;
            border1 <= 1'b0;
            hs_n1   <= 1'b1;
            vs_n1   <= 1'b1;
            v_act1  <= 1'b0;
        end else begin
            active1 <= active0;
            border1 <= border0;
            hs_n1   <= hs_n0;
            vs_n1   <= vs_n0;
            v_act1  <= v_act0;
        end
    end

    assign lookup_idx = active1 ? fetch_data : border_idx;

    video_palette u_palette (
        .clk   (clk),
        .reset (reset),
        .we    (pal_we),
        .waddr (pal_addr),
        .wdata (pal_data),
        .raddr (lookup_idx),
        .rdata (pal_rgb)
    );

    assign pix_rgb = (active1 || border1) ? pal_rgb : '0;

    // Stage 2: colour and sync leave through the same register stage, so they never skew.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_out <= 1'b1;
            vs_out <= 1'b1;
            vblank <= 1'b1;
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
        end else begin
            hs_out <= hs_n1;
            vs_out <= vs_n1;
            vblank <= !v_act1;
            r_out  <= pix_rgb[R_HI:R_LO];
            g_out  <= pix_rgb[G_HI:G_LO];
            b_out  <= pix_rgb[B_HI:B_LO];
        end
    end

endmodule

// File: tb/tb_video_shifter.sv
// tb/tb_video_shifter.sv - scoreboard bench for video_shifter
module tb_video_shifter;

    localparam int K_RGB  = 0;
    localparam int K_HS   = 1;
    localparam int K_VS   = 2;
    localparam int K_VB   = 3;
    localparam int K_ADDR = 4;
    localparam int WHITE  = 32'h3FFFF;

    logic        clk;
    logic        reset;
    logic [15:0] fetch_addr;
    logic [3:0]  fetch_data;
    logic [3:0]  border_idx;
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [17:0] pal_data;
    logic        hs_out;
    logic        vs_out;
    logic        vblank;
    logic [5:0]  r_out;
    logic [5:0]  g_out;
    logic [5:0]  b_out;

    video_shifter dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .border_idx (border_idx),
        .pal_we     (pal_we),
        .pal_addr   (pal_addr),
        .pal_data   (pal_data),
        .hs_out     (hs_out),
        .vs_out     (vs_out),
        .vblank     (vblank),
        .r_out      (r_out),
        .g_out      (g_out),
        .b_out      (b_out)
    );

    typedef struct {
        int    cyc;
        int    kind;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc;
    int   n_total;
    int   n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Framebuffer: one clock read latency, returns the low address nibble.
    initial fetch_data = 4'd0;
    always @(posedge clk) fetch_data <= fetch_addr[3:0];

    // Clocks since the last reset release; equals the DUT position while inside frame 0.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic int p(input int v, input int h);
        return v * 1024 + h;
    endfunction

    function automatic int pal(input int i);
        return (i << 12) | (i << 6) | i;
    endfunction

    function automatic void push(input int c, input int k, input int v, input string n);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        e.name = n;
        sb.push_back(e);
    endfunction

    function automatic int sample(input int kind);
        case (kind)
            K_RGB:   return 32'({r_out, g_out, b_out});
            K_HS:    return 32'(hs_out);
            K_VS:    return 32'(vs_out);
            K_VB:    return 32'(vblank);
            default: return 32'(fetch_addr);
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every scoreboard entry whose cycle has arrived.
    always @(negedge clk) begin
        if (!reset) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                mon_e = sb.pop_front();
                if (mon_e.cyc < cyc) check({mon_e.name, "_missed"}, cyc, mon_e.cyc);
                else                 check(mon_e.name, sample(mon_e.kind), mon_e.val);
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic pal_write(input int a, input int d);
        @(negedge clk);
        pal_we   = 1'b1;
        pal_addr = a[3:0];
        pal_data = d[17:0];
        @(negedge clk);
        pal_we   = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rgb"},  32'({r_out, g_out, b_out}), 0);
        check({tag, "_hs"},   32'(hs_out), 1);
        check({tag, "_vs"},   32'(vs_out), 1);
        check({tag, "_vb"},   32'(vblank), 1);
        check({tag, "_addr"}, 32'(fetch_addr), 0);
    endtask

    task automatic push_hsync_after_release();
        push(801,  K_HS, 1, "hs_pre_fall");
        push(802,  K_HS, 0, "hs_first_fall");
        push(877,  K_HS, 0, "hs_last_low");
        push(878,  K_HS, 1, "hs_rise");
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
        reset      = 1'b1;
        border_idx = 4'd5;
        pal_we     = 1'b0;
        pal_addr   = 4'd0;
        pal_data   = 18'd0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_init");
        reset = 1'b0;

        // Frame after power-up reset: sync timing, border, pixel path, collision.
        push(2, K_VB, 1, "vblank_line0");
        push_hsync_after_release();
        push(p(1, 801), K_HS, 1, "hs_l1_pre");
        push(p(1, 802), K_HS, 0, "hs_l1_fall");
        push(p(10, 702), K_RGB, WHITE, "border_l10_h700");
        push(p(10, 702), K_VB,  1,     "vblank_l10");
        push(p(10, 785), K_RGB, WHITE, "border_last_h783");
        push(p(10, 786), K_RGB, 0,     "blank_first_h784");
        push(p(10, 902), K_RGB, 0,     "blank_h900");
        push(p(56, 1),   K_RGB, 0,     "blank_l55_end");
        push(p(56, 1),   K_VB,  1,     "vblank_l55_end");
        push(p(56, 2), K_RGB, pal(0), "pix_l56_h0");
        push(p(56, 2), K_VB,  0,      "vblank_l56");
        push(p(56, 3), K_RGB, pal(0), "pix_l56_h1");
        push(p(56, 4), K_RGB, pal(1), "pix_l56_h2");
        push(p(56, 5), K_RGB, pal(1), "pix_l56_h3");
        push(p(56, 6), K_RGB, pal(2), "pix_l56_h4");
        push(p(56, 7), K_RGB, pal(2), "pix_l56_h5");
        push(p(56, 641), K_RGB, pal(15), "pix_l56_last");
        push(p(56, 642), K_RGB, WHITE,   "border_l56_h640");
        push(p(57, 0),   K_ADDR, 320,    "addr_l57_start");
        push(p(57, 4),   K_RGB, pal(1),  "pix_l57_h2");
        push(p(60, 8),   K_RGB, pal(3),  "collision_old");
        push(p(60, 9),   K_RGB, 32'h00FC0, "collision_new");
        push(p(100, 300), K_RGB, WHITE, "pix_l100_h298");
        push(p(100, 300), K_VB,  0,     "vblank_l100");

        wait_cyc(10);
        for (int i = 0; i < 16; i++) pal_write(i, (i == 5) ? WHITE : pal(i));

        // Write entry 3 in the same cycle that stage 1 looks up position (60,6).
        wait_cyc(p(60, 7));
        pal_we   = 1'b1;
        pal_addr = 4'd3;
        pal_data = 18'h00FC0;
        @(negedge clk);
        pal_we   = 1'b0;

        // Mid-line reset at (100,300): outputs must clear before any clock edge.
        wait_cyc(p(100, 300));
        #3 reset = 1'b1;
        #1 check_reset_values("reset_async");
        check("sb_empty_at_reset", sb.size(), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Restarted frame: timing from (0,0), cleared palette, address range, vsync.
        push_hsync_after_release();
        push(p(10, 702),   K_RGB, 0,     "pal_cleared_l10");
        push(p(55, 1023),  K_ADDR, 0,     "addr_before_active");
        push(p(56, 2),     K_ADDR, 1,     "addr_l56_h2");
        push(p(255, 639),  K_ADDR, 63999, "addr_last_pixel");
        push(p(255, 640),  K_ADDR, 64000, "addr_after_last");
        push(p(256, 0),    K_ADDR, 64000, "addr_hold_l256");
        push(p(256, 1),    K_VB,  0,      "vblank_l255_end");
        push(p(256, 2),    K_VB,  1,      "vblank_l256");
        push(p(281, 702),  K_RGB, WHITE,  "border_l281");
        push(p(282, 702),  K_RGB, 0,      "blank_l282");
        push(p(290, 1),    K_VS,  1,      "vs_pre_fall");
        push(p(290, 2),    K_VS,  0,      "vs_fall");
        push(p(293, 1),    K_VS,  0,      "vs_last_low");
        push(p(293, 2),    K_VS,  1,      "vs_rise");
        push(p(295, 702),  K_RGB, 0,      "blank_l295");
        push(p(300, 0),    K_ADDR, 64000, "addr_hold_l300");
        push(p(311, 1023), K_ADDR, 64000, "addr_frame_end");
        push(p(312, 0),    K_ADDR, 0,     "addr_frame_wrap");
        push(p(312, 801),  K_HS,  1,      "hs_f1_pre");
        push(p(312, 802),  K_HS,  0,      "hs_f1_fall");

        wait_cyc(p(20, 0));
        pal_write(5, WHITE);

        wait_cyc(p(312, 810));
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
